// File: rtl/ahb_bus_arbiter_if.sv
// Shared-bus signal bundle between the two AHB masters and the arbiter.
// The arbiter connects through the slave modport; a master-side model uses the master modport.
interface ahb_bus_arbiter_if;
  logic        M0_REQ;
  logic        M1_REQ;
  logic        M0_LOCK;
  logic        M1_LOCK;
  logic [1:0]  M0_HTRANS;
  logic [1:0]  M1_HTRANS;
  logic [31:0] M0_HADDR;
  logic [31:0] M1_HADDR;
  logic        M0_HWRITE;
  logic        M1_HWRITE;
  logic [2:0]  M0_HSIZE;
  logic [2:0]  M1_HSIZE;
  logic [2:0]  M0_HBURST;
  logic [2:0]  M1_HBURST;
  logic [3:0]  M0_HPROT;
  logic [3:0]  M1_HPROT;
  logic [63:0] M0_HWDATA;
  logic [63:0] M1_HWDATA;

  logic        HREADY;
  logic        HRESP;

  logic        M0_GRANT;
  logic        M1_GRANT;
  logic        HMASTER;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;

  modport slave (
    input  M0_REQ, M1_REQ, M0_LOCK, M1_LOCK,
    input  M0_HTRANS, M1_HTRANS, M0_HADDR, M1_HADDR,
    input  M0_HWRITE, M1_HWRITE, M0_HSIZE, M1_HSIZE,
    input  M0_HBURST, M1_HBURST, M0_HPROT, M1_HPROT,
    input  M0_HWDATA, M1_HWDATA,
    input  HREADY, HRESP,
    output M0_GRANT, M1_GRANT, HMASTER,
    output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport master (
    output M0_REQ, M1_REQ, M0_LOCK, M1_LOCK,
    output M0_HTRANS, M1_HTRANS, M0_HADDR, M1_HADDR,
    output M0_HWRITE, M1_HWRITE, M0_HSIZE, M1_HSIZE,
    output M0_HBURST, M1_HBURST, M0_HPROT, M1_HPROT,
    output M0_HWDATA, M1_HWDATA,
    output HREADY, HRESP,
    input  M0_GRANT, M1_GRANT, HMASTER,
    input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master round-robin AHB arbiter for the host/DMA shared bus; grant is held
// across locked sequences and fixed-length bursts and only moves on HREADY=1 edges.
module ahb_bus_arbiter (
  input logic              HCLK,
  input logic              HRESET,
  ahb_bus_arbiter_if.slave bus
);

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } master_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  master_e    owner_q, owner_d;
  master_e    downer_q, downer_d;
  logic [4:0] beats_q, beats_d;

  logic       own_m1;
  logic       sel_lock;
  logic       other_req;
  logic [1:0] sel_htrans;
  logic [2:0] sel_hburst;
  logic [4:0] burst_len;

  // During reset master 0 owns the bus regardless of the owner register.
  assign own_m1 = HRESET & (owner_q == MST1);

  assign sel_lock   = own_m1 ? bus.M1_LOCK   : bus.M0_LOCK;
  assign sel_htrans = own_m1 ? bus.M1_HTRANS : bus.M0_HTRANS;
  assign sel_hburst = own_m1 ? bus.M1_HBURST : bus.M0_HBURST;
  assign other_req  = own_m1 ? bus.M0_REQ    : bus.M1_REQ;

  always_comb begin
    burst_len = 5'd1;
    unique case (sel_hburst)
      3'b000, 3'b001: burst_len = 5'd1;
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      3'b110, 3'b111: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  end

  // NOTE: every variable written here gets a default first so a missed branch
  // holds state through the register instead of inferring a latch.
  always_comb begin
    owner_d  = owner_q;
    downer_d = downer_q;
    beats_d  = beats_q;

    if (bus.HREADY) begin
      downer_d = owner_q;

      if (bus.HRESP) begin
        beats_d = '0;
      end else if (sel_htrans == HTRANS_NONSEQ) begin
        beats_d = burst_len - 5'd1;
      end else if (sel_htrans == HTRANS_SEQ && beats_q != '0) begin
        beats_d = beats_q - 5'd1;
      end

      // Park on the current owner when the other master is silent.
      if (beats_d == '0 && !sel_lock && other_req) begin
        owner_d = (owner_q == MST0) ? MST1 : MST0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      owner_q  <= MST0;
      downer_q <= MST0;
      beats_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      downer_q <= downer_d;
      beats_q  <= beats_d;
    end
  end

  assign bus.M0_GRANT  = ~own_m1;
  assign bus.M1_GRANT  = own_m1;
  assign bus.HMASTER   = own_m1;

  assign bus.HTRANS    = HRESET ? sel_htrans : HTRANS_IDLE;
  assign bus.HMASTLOCK = HRESET & sel_lock;
  assign bus.HADDR     = own_m1 ? bus.M1_HADDR  : bus.M0_HADDR;
  assign bus.HWRITE    = own_m1 ? bus.M1_HWRITE : bus.M0_HWRITE;
  assign bus.HSIZE     = own_m1 ? bus.M1_HSIZE  : bus.M0_HSIZE;
  assign bus.HBURST    = sel_hburst;
  assign bus.HPROT     = own_m1 ? bus.M1_HPROT  : bus.M0_HPROT;

  // Write data belongs to the data phase, which lags the address phase by one accept.
  assign bus.HWDATA    = (downer_q == MST1) ? bus.M1_HWDATA : bus.M0_HWDATA;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scenario bench for the two-master AHB arbiter: expectations are queued when
// stimulus is applied and popped when the corresponding bus output is sampled.
module tb_ahb_bus_arbiter;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter_if bus ();

  ahb_bus_arbiter dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  localparam logic [1:0]  IDLE = 2'b00;
  localparam logic [1:0]  NSQ  = 2'b10;
  localparam logic [1:0]  SEQ  = 2'b11;
  localparam logic [31:0] A0   = 32'h0000_1000;
  localparam logic [31:0] A1   = 32'h8000_2000;

  typedef struct {
    logic       rst_n;
    logic       r0, r1, l0, l1;
    logic [1:0] t0, t1;
    logic [2:0] b0, b1;
    logic       rdy, rsp;
  } cyc_t;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic cyc_t cy(logic rst_n, logic r0, logic r1, logic l0, logic l1,
                              logic [1:0] t0, logic [1:0] t1, logic [2:0] b0,
                              logic [2:0] b1, logic rdy, logic rsp);
    cyc_t c;
    c.rst_n = rst_n; c.r0 = r0; c.r1 = r1; c.l0 = l0; c.l1 = l1;
    c.t0 = t0; c.t1 = t1; c.b0 = b0; c.b1 = b1; c.rdy = rdy; c.rsp = rsp;
    return c;
  endfunction

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb_q.size() == 0) begin
      e.tag = "scoreboard_underflow";
      e.val = 'x;
    end else begin
      e = sb_q.pop_front();
    end
    return e;
  endfunction

  task automatic drive(input cyc_t c);
    HRESET        = c.rst_n;
    bus.M0_REQ    = c.r0;
    bus.M1_REQ    = c.r1;
    bus.M0_LOCK   = c.l0;
    bus.M1_LOCK   = c.l1;
    bus.M0_HTRANS = c.t0;
    bus.M1_HTRANS = c.t1;
    bus.M0_HBURST = c.b0;
    bus.M1_HBURST = c.b1;
    bus.HREADY    = c.rdy;
    bus.HRESP     = c.rsp;
  endtask

  task automatic next_edge();
    @(posedge HCLK);
    #1;
  endtask

  // Reset forces master 0 and idles the bus even while master 0 drives NONSEQ+LOCK.
  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(cy(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, NSQ, IDLE, 3'b000, 3'b000, 1'b1, 1'b0));
      push_exp("rst_htrans", 64'd0);
      push_exp("rst_mastlock", 64'd0);
      push_exp("rst_m0_grant", 64'd1);
      #1;
      e = pop_exp(); n_cmp++;
      if ({62'd0, bus.HTRANS} !== e.val) begin
        n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HTRANS, e.val);
      end
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.HMASTLOCK} !== e.val) begin
        n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HMASTLOCK, e.val);
      end
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.M0_GRANT} !== e.val) begin
        n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.M0_GRANT, e.val);
      end
      next_edge();
    end
    drive(cy(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, IDLE, 3'b000, 3'b000, 1'b1, 1'b0));
    push_exp("release_m1_grant", 64'd1);
    push_exp("release_hmaster", 64'd1);
    next_edge();
    e = pop_exp(); n_cmp++;
    if ({63'd0, bus.M1_GRANT} !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.M1_GRANT, e.val);
    end
    e = pop_exp(); n_cmp++;
    if ({63'd0, bus.HMASTER} !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HMASTER, e.val);
    end
  endtask

  // Both request singles every cycle; the owner starts at master 1.
  task automatic test_round_robin();
    exp_t e;
    logic rr_exp[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic cur = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, cur ? IDLE : NSQ, cur ? NSQ : IDLE,
               3'b000, 3'b000, 1'b1, 1'b0));
      push_exp("rr_haddr", {32'd0, cur ? A1 : A0});
      push_exp("rr_hmaster", {63'd0, rr_exp[i]});
      #1;
      e = pop_exp(); n_cmp++;
      if ({32'd0, bus.HADDR} !== e.val) begin
        n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HADDR, e.val);
      end
      next_edge();
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.HMASTER} !== e.val) begin
        n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.tag, i, bus.HMASTER, e.val);
      end
      cur = rr_exp[i];
    end
  endtask

  // Moves ownership from master 1 to master 0 with a single idle request cycle.
  task automatic claim_m0(input string tag);
    exp_t e;
    drive(cy(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, IDLE, 3'b000, 3'b000, 1'b1, 1'b0));
    push_exp(tag, 64'd0);
    next_edge();
    e = pop_exp(); n_cmp++;
    if ({63'd0, bus.HMASTER} !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HMASTER, e.val);
    end
  endtask

  task automatic test_data_phase();
    exp_t e;
    bus.M0_HWDATA = 64'hABCDEF1234567890;
    bus.M1_HWDATA = 64'h0000_0000_0000_1111;
    claim_m0("data_claim_m0");
    drive(cy(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NSQ, IDLE, 3'b000, 3'b000, 1'b1, 1'b0));
    push_exp("data_handover", 64'd1);
    next_edge();
    e = pop_exp(); n_cmp++;
    if ({63'd0, bus.HMASTER} !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HMASTER, e.val);
    end
    drive(cy(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, NSQ, 3'b000, 3'b000, 1'b1, 1'b0));
    push_exp("hwdata_prev_owner", 64'hABCDEF1234567890);
    #1;
    e = pop_exp(); n_cmp++;
    if (bus.HWDATA !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HWDATA, e.val);
    end
    next_edge();
    drive(cy(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, IDLE, 3'b000, 3'b000, 1'b1, 1'b0));
    push_exp("hwdata_new_owner", 64'h1111);
    #1;
    e = pop_exp(); n_cmp++;
    if (bus.HWDATA !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HWDATA, e.val);
    end
    next_edge();
  endtask

  // INCR4 from master 0 with a wait state on beat 3; master 1 requests throughout.
  task automatic test_fixed_burst();
    exp_t e;
    cyc_t tab[5];
    logic m1_exp[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[0] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, IDLE, 3'b011, 3'b000, 1'b1, 1'b0);
    tab[1] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEQ, IDLE, 3'b011, 3'b000, 1'b1, 1'b0);
    tab[2] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEQ, IDLE, 3'b011, 3'b000, 1'b0, 1'b0);
    tab[3] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEQ, IDLE, 3'b011, 3'b000, 1'b1, 1'b0);
    tab[4] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEQ, IDLE, 3'b011, 3'b000, 1'b1, 1'b0);
    claim_m0("burst_claim_m0");
    for (int i = 0; i < 5; i++) begin
      drive(tab[i]);
      push_exp("burst_m1_grant", {63'd0, m1_exp[i]});
      next_edge();
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.M1_GRANT} !== e.val) begin
        n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.tag, i, bus.M1_GRANT, e.val);
      end
    end
  endtask

  // Master 1 owns and issues three locked singles, then one unlocked single.
  task automatic test_lock();
    exp_t e;
    logic m0_exp[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(cy(1'b1, 1'b1, 1'b1, 1'b0, (i < 3), IDLE, NSQ, 3'b000, 3'b000, 1'b1, 1'b0));
      push_exp("lock_mastlock", (i < 3) ? 64'd1 : 64'd0);
      push_exp("lock_m0_grant", {63'd0, m0_exp[i]});
      #1;
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.HMASTLOCK} !== e.val) begin
        n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.tag, i, bus.HMASTLOCK, e.val);
      end
      next_edge();
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.M0_GRANT} !== e.val) begin
        n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.tag, i, bus.M0_GRANT, e.val);
      end
    end
  endtask

  // WRAP8 from master 0 cut short by a two-cycle ERROR response on beat 2.
  task automatic test_error_cancel();
    exp_t e;
    cyc_t tab[3];
    logic own_exp[3] = '{1'b0, 1'b0, 1'b1};
    tab[0] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, IDLE, 3'b100, 3'b000, 1'b1, 1'b0);
    tab[1] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEQ, IDLE, 3'b100, 3'b000, 1'b0, 1'b1);
    tab[2] = cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SEQ, IDLE, 3'b100, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(tab[i]);
      push_exp("error_hmaster", {63'd0, own_exp[i]});
      next_edge();
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.HMASTER} !== e.val) begin
        n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.tag, i, bus.HMASTER, e.val);
      end
    end
  endtask

  // With no requests the bus parks on master 1; a lone master 0 request then wins.
  task automatic test_park();
    exp_t e;
    logic own_exp[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(cy(1'b1, (i == 2), 1'b0, 1'b0, 1'b0, IDLE, IDLE, 3'b000, 3'b000, 1'b1, 1'b0));
      push_exp("park_hmaster", {63'd0, own_exp[i]});
      next_edge();
      e = pop_exp(); n_cmp++;
      if ({63'd0, bus.HMASTER} !== e.val) begin
        n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.tag, i, bus.HMASTER, e.val);
      end
    end
  endtask

  // Reset lands in the middle of an INCR16; afterwards the beat count must be clear.
  task automatic test_reset_mid_burst();
    exp_t e;
    drive(cy(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, IDLE, 3'b111, 3'b000, 1'b1, 1'b0));
    push_exp("midrst_hold", 64'd0);
    next_edge();
    e = pop_exp(); n_cmp++;
    if ({63'd0, bus.HMASTER} !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HMASTER, e.val);
    end
    drive(cy(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SEQ, IDLE, 3'b111, 3'b000, 1'b1, 1'b0));
    push_exp("midrst_htrans", 64'd0);
    #1;
    e = pop_exp(); n_cmp++;
    if ({62'd0, bus.HTRANS} !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.HTRANS, e.val);
    end
    next_edge();
    drive(cy(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, IDLE, 3'b111, 3'b000, 1'b1, 1'b0));
    push_exp("midrst_handover", 64'd1);
    next_edge();
    e = pop_exp(); n_cmp++;
    if ({63'd0, bus.M1_GRANT} !== e.val) begin
      n_err++; $display("FAIL %s: observed %h expected %h", e.tag, bus.M1_GRANT, e.val);
    end
  endtask

  initial begin
    bus.M0_HADDR  = A0;
    bus.M1_HADDR  = A1;
    bus.M0_HWRITE = 1'b1;
    bus.M1_HWRITE = 1'b0;
    bus.M0_HSIZE  = 3'b011;
    bus.M1_HSIZE  = 3'b010;
    bus.M0_HPROT  = 4'b0011;
    bus.M1_HPROT  = 4'b0001;
    bus.M0_HWDATA = 64'h0;
    bus.M1_HWDATA = 64'h0;

    test_reset();
    test_round_robin();
    test_data_phase();
    test_fixed_burst();
    test_lock();
    test_error_cancel();
    test_park();
    test_reset_mid_burst();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
